// File: rtl/sync_pkg.sv
// Shared constants and helpers for the write-to-read gray pointer synchronizers.
// The helpers work on a fixed maximum width, so callers zero-extend and then truncate.
package sync_pkg;

    localparam int SYNC_STAGES_MIN = 2;
    localparam int SYNC_STAGES_MAX = 4;
    localparam int PTR_W_MAX       = 32;

    // Leading zeros in a gray code convert to leading zeros in binary.
    // That lets one fixed-width routine serve every pointer width up to PTR_W_MAX.
    function automatic logic [PTR_W_MAX-1:0] gray2bin(input logic [PTR_W_MAX-1:0] g);
        logic [PTR_W_MAX-1:0] b;
        b[PTR_W_MAX-1] = g[PTR_W_MAX-1];
        for (int i = PTR_W_MAX - 2; i >= 0; i--) begin
            b[i] = b[i+1] ^ g[i];
        end
        return b;
    endfunction

    // Clearing the lowest set bit leaves a nonzero value only if two or more bits were set.
    function automatic logic popcount_gt1(input logic [PTR_W_MAX-1:0] v);
        return (v & (v - PTR_W_MAX'(1))) != '0;
    endfunction

endpackage

// File: rtl/sync_w2r_chan.sv
// One channel: gray pointer flop chain into rclk, then change detection, binary conversion,
// increment count, update pulse and sticky multi-bit-change error.
module sync_w2r_chan
    import sync_pkg::*;
#(
    parameter int ADDRSIZE    = 5,
    parameter int SYNC_STAGES = 2
) (
    input  logic              rclk,
    input  logic              rrst_n,
    input  logic [ADDRSIZE:0] wptr,
    input  logic              err_clr,
    output logic [ADDRSIZE:0] rq_wptr,
    output logic [ADDRSIZE:0] rq_wbin,
    output logic [ADDRSIZE:0] rq_delta,
    output logic              rq_upd,
    output logic              rq_err
);

    localparam int W = ADDRSIZE + 1;

    logic [W-1:0] sync_q [SYNC_STAGES];
    logic [W-1:0] g_last;
    logic [W-1:0] bin_next;
    logic         changed;
    logic         multi;

    always_ff @(posedge rclk or negedge rrst_n) begin
        if (!rrst_n) begin
            for (int k = 0; k < SYNC_STAGES; k++) begin
                sync_q[k] <= '0;
            end
        end else begin
            sync_q[0] <= wptr;
            for (int k = 1; k < SYNC_STAGES; k++) begin
                sync_q[k] <= sync_q[k-1];
            end
        end
    end

    // The last stage is itself a flop, so no input reaches an output combinationally.
    assign rq_wptr = sync_q[SYNC_STAGES-1];

    always_comb begin
        bin_next = W'(gray2bin(PTR_W_MAX'(rq_wptr)));
        changed  = rq_wptr != g_last;
        multi    = popcount_gt1(PTR_W_MAX'(rq_wptr ^ g_last));
    end

    always_ff @(posedge rclk or negedge rrst_n) begin
        if (!rrst_n) begin
            g_last   <= '0;
            rq_wbin  <= '0;
            rq_delta <= '0;
            rq_upd   <= 1'b0;
            rq_err   <= 1'b0;
        end else begin
            rq_upd <= changed;
            if (changed) begin
                g_last   <= rq_wptr;
                rq_wbin  <= bin_next;
                rq_delta <= bin_next - rq_wbin;
            end
            // A fresh multi-bit change wins over a clear arriving in the same cycle.
            if (changed && multi) begin
                rq_err <= 1'b1;
            end else if (err_clr) begin
                rq_err <= 1'b0;
            end
        end
    end

endmodule

// File: rtl/sync_w2r_multi.sv
// Multi-channel gray write-pointer synchronizer into the read clock domain.
// Slices the buses per channel and rejects illegal parameter values at elaboration.
module sync_w2r_multi
    import sync_pkg::*;
#(
    parameter int ADDRSIZE    = 5,
    parameter int NCH         = 1,
    parameter int SYNC_STAGES = 2
) (
    input  logic                          rclk,
    input  logic                          rrst_n,
    input  logic [NCH*(ADDRSIZE+1)-1:0]   wptr,
    input  logic [NCH-1:0]                err_clr,
    output logic [NCH*(ADDRSIZE+1)-1:0]   rq_wptr,
    output logic [NCH*(ADDRSIZE+1)-1:0]   rq_wbin,
    output logic [NCH*(ADDRSIZE+1)-1:0]   rq_delta,
    output logic [NCH-1:0]                rq_upd,
    output logic [NCH-1:0]                rq_err
);

    localparam int W = ADDRSIZE + 1;

    generate
        if (SYNC_STAGES < SYNC_STAGES_MIN || SYNC_STAGES > SYNC_STAGES_MAX) begin : g_bad_stages
            $error("sync_w2r_multi: SYNC_STAGES=%0d outside %0d..%0d",
                   SYNC_STAGES, SYNC_STAGES_MIN, SYNC_STAGES_MAX);
        end
        if (NCH < 1 || NCH > 16) begin : g_bad_nch
            $error("sync_w2r_multi: NCH=%0d outside 1..16", NCH);
        end
        if (W > PTR_W_MAX) begin : g_bad_width
            $error("sync_w2r_multi: pointer width %0d exceeds %0d", W, PTR_W_MAX);
        end

        for (genvar c = 0; c < NCH; c++) begin : g_chan
            sync_w2r_chan #(
                .ADDRSIZE    (ADDRSIZE),
                .SYNC_STAGES (SYNC_STAGES)
            ) u_chan (
                .rclk     (rclk),
                .rrst_n   (rrst_n),
                .wptr     (wptr[c*W +: W]),
                .err_clr  (err_clr[c]),
                .rq_wptr  (rq_wptr[c*W +: W]),
                .rq_wbin  (rq_wbin[c*W +: W]),
                .rq_delta (rq_delta[c*W +: W]),
                .rq_upd   (rq_upd[c]),
                .rq_err   (rq_err[c])
            );
        end
    endgenerate

endmodule
